// File: rtl/eth_axis_frame_fifo.sv
// rtl/eth_axis_frame_fifo.sv - store-and-forward AXI-stream frame FIFO
// Frames become visible to the read side only once their tlast beat commits.
module eth_axis_frame_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int KEEP_ENABLE    = 0,
  parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
  parameter int DEPTH          = 4096,
  parameter int DROP_BAD_FRAME = 1,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                     logic_clk,
  input  logic                     logic_rst,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tuser,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tuser,
  output logic                     m_axis_startofpacket,
  output logic                     status_overflow,
  output logic                     status_bad_frame,
  output logic                     status_good_frame,
  output logic [$clog2(DEPTH):0]   status_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;
  state_t state, state_n;

  logic [PW-1:0] wr_cur, wr_cur_n, wr_commit, wr_commit_n, rd, rd_n, ra;
  logic full, frame_full, drop_now, accept, mem_we, good_n, bad_n, ovf_n;

  // Word layout: {tuser on tlast, tlast, tdata}
  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [DATA_WIDTH+1:0] mem_q;
  logic mem_vld, fetch, move, pop, next_sop;

  assign full       = (wr_cur - rd) == DEPTH_P;
  assign frame_full = (wr_cur - wr_commit) == DEPTH_P;
  assign drop_now   = full && ((DROP_WHEN_FULL != 0) || frame_full);
  assign s_axis_tready = (state == DROP) || !full || drop_now;
  assign accept     = s_axis_tvalid && s_axis_tready;

  always_comb begin
    state_n     = state;
    wr_cur_n    = wr_cur;
    wr_commit_n = wr_commit;
    mem_we      = 1'b0;
    good_n      = 1'b0;
    bad_n       = 1'b0;
    ovf_n       = 1'b0;
    if (accept) begin
      if (state == DROP || drop_now) begin
        wr_cur_n = wr_commit;
        if (s_axis_tlast) begin
          ovf_n   = 1'b1;
          state_n = IDLE;
        end else begin
          state_n = DROP;
        end
      end else begin
        mem_we   = 1'b1;
        wr_cur_n = wr_cur + 1'b1;
        if (s_axis_tlast) begin
          state_n = IDLE;
          if (s_axis_tuser && (DROP_BAD_FRAME != 0)) begin
            wr_cur_n = wr_commit;
            bad_n    = 1'b1;
          end else begin
            wr_commit_n = wr_cur + 1'b1;
            good_n      = 1'b1;
          end
        end else begin
          state_n = WRITE;
        end
      end
    end
  end

  // rd tracks beats leaving the output register; ra is the prefetch address
  assign pop   = m_axis_tvalid && m_axis_tready;
  assign move  = mem_vld && (!m_axis_tvalid || m_axis_tready);
  assign fetch = (ra != wr_commit) && (!mem_vld || move);
  assign rd_n  = rd + PW'(pop);

  always_ff @(posedge logic_clk) begin
    if (mem_we) mem[wr_cur[AW-1:0]] <= {s_axis_tuser & s_axis_tlast, s_axis_tlast, s_axis_tdata};
    if (fetch) mem_q <= mem[ra[AW-1:0]];
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      state                <= IDLE;
      wr_cur               <= '0;
      wr_commit            <= '0;
      rd                   <= '0;
      ra                   <= '0;
      mem_vld              <= 1'b0;
      next_sop             <= 1'b1;
      m_axis_tvalid        <= 1'b0;
      m_axis_tdata         <= '0;
      m_axis_tlast         <= 1'b0;
      m_axis_tuser         <= 1'b0;
      m_axis_startofpacket <= 1'b0;
      status_overflow      <= 1'b0;
      status_bad_frame     <= 1'b0;
      status_good_frame    <= 1'b0;
      status_level         <= '0;
    end else begin
      state             <= state_n;
      wr_cur            <= wr_cur_n;
      wr_commit         <= wr_commit_n;
      rd                <= rd_n;
      if (fetch) ra     <= ra + 1'b1;
      mem_vld           <= fetch || (mem_vld && !move);
      status_overflow   <= ovf_n;
      status_bad_frame  <= bad_n;
      status_good_frame <= good_n;
      status_level      <= wr_commit_n - rd_n;
      if (move) begin
        m_axis_tvalid        <= 1'b1;
        m_axis_tdata         <= mem_q[DATA_WIDTH-1:0];
        m_axis_tlast         <= mem_q[DATA_WIDTH];
        m_axis_tuser         <= mem_q[DATA_WIDTH+1];
        m_axis_startofpacket <= next_sop;
        next_sop             <= mem_q[DATA_WIDTH];
      end else if (m_axis_tready) begin
        m_axis_tvalid        <= 1'b0;
        m_axis_tlast         <= 1'b0;
        m_axis_tuser         <= 1'b0;
        m_axis_startofpacket <= 1'b0;
      end
    end
  end

  generate
    if (KEEP_ENABLE != 0) begin : g_keep
      logic [KEEP_WIDTH-1:0] keep_mem [DEPTH];
      logic [KEEP_WIDTH-1:0] keep_q;
      always_ff @(posedge logic_clk) begin
        if (mem_we) keep_mem[wr_cur[AW-1:0]] <= s_axis_tkeep;
        if (fetch) keep_q <= keep_mem[ra[AW-1:0]];
      end
      always_ff @(posedge logic_clk or posedge logic_rst) begin
        if (logic_rst) m_axis_tkeep <= '0;
        else if (move) m_axis_tkeep <= keep_q;
      end
    end else begin : g_no_keep
      logic unused_keep;
      assign unused_keep  = ^s_axis_tkeep;
      assign m_axis_tkeep = {KEEP_WIDTH{1'b1}};
    end
  endgenerate
endmodule

// File: tb/tb_eth_axis_frame_fifo.sv
// tb/tb_eth_axis_frame_fifo.sv - scoreboard bench for eth_axis_frame_fifo
// Driver pushes expected beats of frames that must survive; a monitor pops on each output handshake.
module tb_eth_axis_frame_fifo;
  localparam int DW = 16;
  localparam int KW = 2;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser, m_axis_startofpacket;
  logic status_overflow, status_bad_frame, status_good_frame;
  logic [$clog2(DEPTH):0] status_level;

  eth_axis_frame_fifo #(
    .DATA_WIDTH(DW), .KEEP_ENABLE(1), .KEEP_WIDTH(KW), .DEPTH(DEPTH),
    .DROP_BAD_FRAME(1), .DROP_WHEN_FULL(0)
  ) dut (
    .logic_clk(clk), .logic_rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_startofpacket(m_axis_startofpacket), .status_overflow(status_overflow),
    .status_bad_frame(status_bad_frame), .status_good_frame(status_good_frame),
    .status_level(status_level)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          sop;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0, errors = 0;
  int cnt_good = 0, cnt_bad = 0, cnt_ovf = 0;
  int rx_beats = 0, acc_beats = 0, stall_cycles = 0, frame_id = 0;
  bit ready_rand = 1'b0;
  logic ready_force = 1'b1;
  bit t4_done = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      m_axis_tready = ready_rand ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        cnt_good += int'(status_good_frame);
        cnt_bad  += int'(status_bad_frame);
        cnt_ovf  += int'(status_overflow);
      end
    end
  end

  initial begin
    beat_t got, e, prev;
    logic prev_stall;
    prev_stall = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        got = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_startofpacket};
        if (prev_stall) begin
          checks++;
          if (!m_axis_tvalid || got !== prev) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b beat=%h expected valid=1 beat=%h", m_axis_tvalid, got, prev);
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          rx_beats++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat: got %h expected no beat", got);
          end else begin
            e = exp_q.pop_front();
            if (got !== e || m_axis_tuser !== 1'b0) begin
              errors++;
              $display("FAIL out_beat: got %h user=%0b expected %h user=0", got, m_axis_tuser, e);
            end
          end
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev = got;
      end
    end
  end

  task automatic send_frame(input int len, input bit bad, input bit expect_out, input int gap_pct);
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic lst;
    beat_t b;
    bit acc;
    int t;
    frame_id++;
    for (int i = 0; i < len; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      d = {frame_id[7:0], i[7:0]};
      k = KW'($urandom);
      lst = (i == len - 1);
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tlast  = lst;
      s_axis_tuser  = bad && lst;
      s_axis_tvalid = 1'b1;
      if (expect_out) begin
        b.data = d; b.keep = k; b.last = lst; b.sop = (i == 0);
        exp_q.push_back(b);
      end
      t = 0;
      acc = 1'b0;
      while (!acc && t < 2000) begin
        @(negedge clk);
        acc = s_axis_tready;
        if (!acc) stall_cycles++;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no tready in %0d cycles expected acceptance", t);
        break;
      end
      acc_beats++;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
    check({name, "_drained"}, 64'(exp_q.size()), 0);
    check({name, "_level"}, status_level, 0);
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int g0, b0, a0, r0, ngood, nbad, len;
    bit bad;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_tready", s_axis_tready, 1);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_sop", m_axis_startofpacket, 0);
    check("rst_level", status_level, 0);
    check("rst_pulses", {status_overflow, status_bad_frame, status_good_frame}, 0);
    @(posedge clk);
    #1;

    // 60-beat frame, full-rate read, first valid two edges after the tlast edge
    r0 = rx_beats;
    send_frame(60, 0, 1, 0);
    @(negedge clk);
    @(negedge clk);
    check("lat_edge1", m_axis_tvalid, 0);
    @(negedge clk);
    check("lat_edge2", m_axis_tvalid, 1);
    check("lat_sop", m_axis_startofpacket, 1);
    @(posedge clk);
    #1;
    wait_drain("t1");
    check("t1_rx", rx_beats - r0, 60);
    check("t1_good", cnt_good, 1);

    // bad frame dropped, following good frame passes
    send_frame(20, 1, 0, 0);
    send_frame(10, 0, 1, 0);
    wait_drain("t2");
    check("t2_bad", cnt_bad, 1);
    check("t2_good", cnt_good, 2);

    // oversize frame: no backpressure, dropped; then exactly DEPTH beats fits
    stall_cycles = 0;
    send_frame(80, 0, 0, 0);
    check("t3_stalls", stall_cycles, 0);
    repeat (4) @(posedge clk);
    #1;
    check("t3_ovf", cnt_ovf, 1);
    check("t3_valid", m_axis_tvalid, 0);
    check("t3_level", status_level, 0);
    send_frame(DEPTH, 0, 1, 0);
    wait_drain("t3");
    check("t3_good", cnt_good, 3);

    // backpressure: reader stalled, two 40-beat frames
    ready_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a0 = acc_beats;
    t4_done = 1'b0;
    fork
      begin
        send_frame(40, 0, 1, 0);
        send_frame(40, 0, 1, 0);
        t4_done = 1'b1;
      end
    join_none
    repeat (150) @(posedge clk);
    #1;
    check("t4_s_tready", s_axis_tready, 0);
    check("t4_accepted", acc_beats - a0, DEPTH);
    check("t4_level", status_level, 40);
    check("t4_valid_held", m_axis_tvalid, 1);
    ready_force = 1'b1;
    wait (t4_done);
    wait_drain("t4");
    check("t4_good", cnt_good, 5);

    // random traffic with random gaps and output ready
    g0 = cnt_good; b0 = cnt_bad; ngood = 0; nbad = 0;
    ready_rand = 1'b1;
    for (int f = 0; f < 200; f++) begin
      len = $urandom_range(1, DEPTH);
      bad = ($urandom_range(0, 7) == 0);
      if (bad) nbad++; else ngood++;
      send_frame(len, bad, !bad, 30);
    end
    ready_rand = 1'b0;
    ready_force = 1'b1;
    wait_drain("t5");
    check("t5_good", cnt_good - g0, ngood);
    check("t5_bad", cnt_bad - b0, nbad);

    // reset mid-frame with a committed frame waiting at the output
    ready_force = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_frame(5, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      s_axis_tdata = DW'(16'hA500 + i);
      s_axis_tkeep = '1;
      s_axis_tlast = 1'b0;
      s_axis_tvalid = 1'b1;
      @(posedge clk);
      #1;
    end
    check("t6_pre_valid", m_axis_tvalid, 1);
    rst = 1'b1;
    #1;
    check("t6_valid", m_axis_tvalid, 0);
    check("t6_level", status_level, 0);
    check("t6_s_tready", s_axis_tready, 1);
    check("t6_outs", {m_axis_tdata, m_axis_tlast, m_axis_tuser, m_axis_startofpacket}, 0);
    s_axis_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    ready_force = 1'b1;
    g0 = cnt_good;
    repeat (2) @(posedge clk);
    #1;
    send_frame(12, 0, 1, 0);
    wait_drain("t6");
    check("t6_good", cnt_good - g0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
